period_cmp_multi: RTL
=====================

Name: period_cmp_multi

Overview:
Multi-channel clock-period monitor in the sys_clk domain. Synchronises NUM_CH asynchronous clock inputs, detects rising edges, and measures each channel's period in sys_clk cycles. The last complete period per channel is latched, with saturation and stall detection. Any two channels, selected at run time, are compared and the result is registered. Successor to the fixed two-channel, 8-bit period comparator; used for clock-health monitoring and relative-frequency checks.

Parameters:
NUM_CH, 2, number of monitored clock inputs (>=2)
CNT_W, 8, period counter/register width; MAX = 2^CNT_W-1
SYNC_STAGES, 2, synchroniser flops per input (>=2)
SEL_W, $clog2(NUM_CH) (min 1), width of channel selects
TOL, 1, equality tolerance in sys_clk cycles (used only with PERIOD_CMP_TOL_EN)

Ports:
sys_clk  in  1  sole clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
clk_in  in  NUM_CH  asynchronous clocks to monitor
sel_a  in  SEL_W  channel A select
sel_b  in  SEL_W  channel B select
period  out  NUM_CH*CNT_W  latched periods; channel i at [i*CNT_W +: CNT_W]
meas_valid  out  NUM_CH  period[i] holds a valid measurement
stalled  out  NUM_CH  no edge for MAX cycles
a_eq_b  out  1  period A == period B
a_lt_b  out  1  period A < period B
a_gt_b  out  1  period A > period B
cmp_valid  out  1  comparison flags are meaningful

Behaviour:
- Reset (rst_n=0 at posedge): all synchroniser flops, counters, period, meas_valid, stalled, armed, and comparison outputs go to 0. Applying reset mid-measurement discards all state; the arming sequence restarts.
- Per channel: clk_in[i] passes through SYNC_STAGES flops, then one history flop. rise[i] = sync_last & ~history (one-cycle pulse). Latency from input edge to rise pulse: SYNC_STAGES+1 cycles.
- Counter cnt[i]: increments by 1 per cycle and saturates at MAX (never wraps). On rise[i], cnt[i] <= 1.
- First rise after reset, or after a stall: sets armed[i]. No capture; meas_valid[i] stays 0.
- Rise while armed: period[i] <= cnt[i] and meas_valid[i] <= 1. Two rises N sys_clk cycles apart give period = N.
- Stall: if cnt[i]==MAX and no rise in that cycle, then next cycle stalled[i]=1, meas_valid[i]=0, armed[i]=0, and period[i] holds its old value.
- Next rise after a stall: stalled[i] <= 0 and re-arm only. A valid measurement requires a second rise.
- Rise in the same cycle as cnt==MAX: normal capture (period=MAX). No stall.
- Comparison: registered, 1 cycle after any change of period, meas_valid, or sel.
- cmp_valid = sel_a<NUM_CH & sel_b<NUM_CH & meas_valid[sel_a] & meas_valid[sel_b].
- When cmp_valid=0, a_eq_b, a_lt_b and a_gt_b are all 0. When cmp_valid=1, exactly one flag is 1.
- sel_a==sel_b with a valid channel gives a_eq_b=1.
- Comparisons are unsigned, CNT_W bits.
- Input clocks must be slower than sys_clk/2. Faster inputs alias; this is not detected.

Optional Feature:
PERIOD_CMP_TOL_EN:
- Defined: a_eq_b=1 when |A-B| <= TOL, computed without underflow. Otherwise a_lt_b or a_gt_b as usual.
- Undefined: exact equality; TOL is ignored and no tolerance logic is synthesised.

Test Plan:
- Basic measurement (sys_clk 10 ns, clk_in[0]=100 ns, clk_in[1]=150 ns, sel_a=0, sel_b=1) -> after two rises per channel: period[0]=10, period[1]=15, meas_valid=2'b11, cmp_valid=1, a_lt_b=1.
- Swap selects to sel_a=1, sel_b=0 -> one cycle later a_gt_b=1. Set sel_a=sel_b=0 -> a_eq_b=1.
- Stall: hold clk_in[1] low (CNT_W=8) -> 255 cycles after the last rise[1], stalled[1]=1, meas_valid[1]=0, cmp_valid=0, all flags 0. Restart the clock -> meas_valid[1] returns only after the second rise.
- Reset mid-operation: assert rst_n=0 for one cycle while measuring -> next cycle all outputs 0. The first post-reset rise does not capture.
- Out-of-range select (NUM_CH=3, SEL_W=2, sel_b=3) -> cmp_valid=0 and all flags 0, regardless of meas_valid.
- With PERIOD_CMP_TOL_EN and TOL=1: periods 10 vs 11 -> a_eq_b=1; 10 vs 12 -> a_lt_b=1. Without the macro: 10 vs 11 -> a_lt_b=1.

Source files
------------

// File: rtl/period_cmp_multi.sv
// period_cmp_multi: multi-channel clock-period monitor and run-time selectable period comparator.
// Ports:
//   sys_clk            sole clock, all logic on posedge
//   rst_n              synchronous active-low reset
//   clk_in[NUM_CH]     asynchronous clocks to monitor
//   sel_a, sel_b       channel selects for the comparison
//   period             last complete period per channel, channel i at [i*CNT_W +: CNT_W]
//   meas_valid         period[i] holds a valid measurement
//   stalled            channel saw no rising edge for 2^CNT_W-1 cycles
//   a_eq_b/a_lt_b/a_gt_b  registered comparison of period[sel_a] against period[sel_b]
//   cmp_valid          comparison flags are meaningful
// Build option: define PERIOD_CMP_TOL_EN to treat |A-B| <= TOL as equal.
module period_cmp_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TOL         = 1
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        clk_in,
    input  logic [SEL_W-1:0]         sel_a,
    input  logic [SEL_W-1:0]         sel_b,
    output logic [NUM_CH*CNT_W-1:0]  period,
    output logic [NUM_CH-1:0]        meas_valid,
    output logic [NUM_CH-1:0]        stalled,
    output logic                     a_eq_b,
    output logic                     a_lt_b,
    output logic                     a_gt_b,
    output logic                     cmp_valid
);
    localparam logic [CNT_W-1:0] MAX = '1;

    if (NUM_CH < 2) begin : g_bad_ch
        $error("NUM_CH must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TOL < 0) begin : g_bad_tol
        $error("TOL must be non-negative");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   hist;
        logic                   armed;
        logic                   mv;
        logic                   st;
        logic                   rise;
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W-1:0]       per;
        assign rise = sync_q[SYNC_STAGES-1] & ~hist;
        always_ff @(posedge sys_clk) begin
            if (!rst_n) begin
                sync_q <= '0;
                hist   <= 1'b0;
                armed  <= 1'b0;
                mv     <= 1'b0;
                st     <= 1'b0;
                cnt    <= '0;
                per    <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in[i]};
                hist   <= sync_q[SYNC_STAGES-1];
                cnt    <= rise ? CNT_W'(1) : (cnt == MAX ? cnt : cnt + 1'b1);
                // a rise always (re)arms; it captures only if a previous rise armed it
                if (rise) begin
                    armed <= 1'b1;
                    st    <= 1'b0;
                    if (armed) begin
                        per <= cnt;
                        mv  <= 1'b1;
                    end
                end else if (cnt == MAX) begin
                    st    <= 1'b1;
                    mv    <= 1'b0;
                    armed <= 1'b0;
                end
            end
        end
        assign period[i*CNT_W +: CNT_W] = per;
        assign meas_valid[i]            = mv;
        assign stalled[i]               = st;
    end

    logic             va, vb, cv_n, eq_n, lt_n;
    logic [SEL_W-1:0] ia, ib;
    logic [CNT_W-1:0] pa, pb;
`ifdef PERIOD_CMP_TOL_EN
    logic [CNT_W-1:0] diff;
`endif

    always_comb begin
        va   = int'(sel_a) < NUM_CH;
        vb   = int'(sel_b) < NUM_CH;
        // out-of-range selects are steered to channel 0 so indexing stays in bounds
        ia   = va ? sel_a : '0;
        ib   = vb ? sel_b : '0;
        pa   = period[int'(ia)*CNT_W +: CNT_W];
        pb   = period[int'(ib)*CNT_W +: CNT_W];
        cv_n = va & vb & meas_valid[ia] & meas_valid[ib];
`ifdef PERIOD_CMP_TOL_EN
        // subtract the smaller from the larger so the difference never underflows
        diff = pa > pb ? pa - pb : pb - pa;
        eq_n = int'(diff) <= TOL;
`else
        eq_n = pa == pb;
`endif
        lt_n = ~eq_n & (pa < pb);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cmp_valid <= 1'b0;
            a_eq_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            a_gt_b    <= 1'b0;
        end else begin
            cmp_valid <= cv_n;
            a_eq_b    <= cv_n & eq_n;
            a_lt_b    <= cv_n & lt_n;
            a_gt_b    <= cv_n & ~eq_n & ~lt_n;
        end
    end
endmodule
